dsm_modulator: RTL and testbench
================================

# dsm_modulator

Parametrised delta-sigma modulator: a successor to the team's combinational delta/feedback stage that adds the registered integrator chain, the 1-bit quantiser and sample-enable control. It supports first- or second-order loops, configurable integrator headroom and feedback magnitude, and saturating integrators with a sticky overflow flag. The block sits between the signed sample source and the 1-bit pulse-density output path.

## Interface
- DATA_WIDTH, 4: signed input sample width.
- ADDITIONAL_DELTA_WIDTH, 2: integrator headroom bits; IW = DATA_WIDTH + ADDITIONAL_DELTA_WIDTH.
- FEEDBACK_MAG, 8: feedback magnitude, a signed integer; legal range 1 to 2^(IW-1)-1.
- ORDER, 2: loop order, 1 or 2; any other value is illegal.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  reset; one clock, reset is asynchronous and active-low.
- i_en  in  1  sample enable; the loop advances one step per enabled cycle.
- i_clear  in  1  synchronous clear of loop state and flags.
- i_data  in  DATA_WIDTH  signed input sample, sampled when i_en=1.
- o_bit  out  1  quantised output bit (1 = +FEEDBACK_MAG, 0 = -FEEDBACK_MAG).
- o_valid  out  1  one-cycle strobe: o_bit was updated this cycle.
- o_sat  out  1  sticky flag: an integrator clamped since the last reset or clear.

## Operation
- State: signed IW-bit int1 and int2; int2 is unused and held at 0 when ORDER=1.
- Quantiser (combinational, from registered state): q = (intN >= 0), with N = ORDER.
- Feedback: fb = q ? +FEEDBACK_MAG : -FEEDBACK_MAG, sign-extended to IW bits.
- i_data is sign-extended to IW bits. All sums are computed at IW+2 bits, then saturated to [-2^(IW-1), 2^(IW-1)-1].
- On an enabled step (i_en=1, i_clear=0):
  - int1 <= sat(int1 + x - fb).
  - int2 <= sat(int2 + int1_old - fb), using the pre-update int1. This is the delaying-integrator CIFB topology.
  - o_bit <= q.
  - o_valid <= 1.
  - o_sat <= o_sat | (any clamp this step).
- i_en=0: state, o_bit and o_sat hold; o_valid <= 0.
- i_clear=1 takes priority over i_en. int1, int2, o_bit, o_valid and o_sat all go to 0 on that edge.
- A clamp is flagged only when the unsaturated sum lies outside the IW range. Reaching the range limit exactly does not set o_sat.

## Timing
- Asynchronous reset state: int1 = int2 = 0, o_bit = 0, o_valid = 0, o_sat = 0.
- Reset asserted mid-stream forces that state immediately, without waiting for a clock edge.
- The first enabled step after reset or clear yields q = 1, because intN = 0 counts as >= 0.
- Latency: o_bit and o_valid are registered and appear one cycle after the enabled edge that sampled i_data.
- o_valid follows i_en delayed by one cycle, and is masked on the edge after i_clear.
- Back-to-back enables are fully supported: one output bit per clock, no stall.
- o_sat updates in the same edge as the clamping step and then stays high until reset or clear.

## Test plan
All scenarios use DATA_WIDTH=4, ADDITIONAL_DELTA_WIDTH=2 (IW=6, range -32..31), FEEDBACK_MAG=8.

1. Reset, ORDER=1, i_en=1 continuously, x=0.
   - Required: o_bit sequence 1,0,1,0,…
   - Required: int1 alternates -8, 0.
   - Required: o_sat stays 0.
2. ORDER=1, x=+4 constant, 16 enables from reset.
   - Required: exactly 12 ones in the 16 o_bit values (density 0.75).
   - Required: o_valid high on 16 cycles.
3. ORDER=2, x=-8, continuous enables from reset.
   - Required: o_bit = 1, then 0 thereafter.
   - Required: int2 = -8, -16, -24, -32, then clamps at -32.
   - Required: o_sat rises on the 5th step and stays 1.
4. Enable gating: toggle i_en 1,0,0,1 with x=+4.
   - Required: o_valid pulses only after the enabled cycles.
   - Required: int1, int2 and o_bit hold across the disabled cycles.
5. Clear versus enable: assert i_clear together with i_en while o_sat=1.
   - Required: next cycle int1=int2=0, o_bit=0, o_valid=0, o_sat=0.
   - Required: the following enabled step outputs o_bit=1.
6. Asynchronous reset mid-stream: drop i_rst_n between clock edges.
   - Required: all outputs 0 before the next edge.
   - Required: after release, behaviour is identical to scenario 1.

Source files
------------

// File: rtl/dsm_modulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dsm_modulator: 1st/2nd-order CIFB delta-sigma loop, 1-bit quantiser.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module dsm_modulator #(
  parameter int DATA_WIDTH             = 4,
  parameter int ADDITIONAL_DELTA_WIDTH = 2,
  parameter int FEEDBACK_MAG           = 8,
  parameter int ORDER                  = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_en,
  input  logic                         i_clear,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_bit,
  output logic                         o_valid,
  output logic                         o_sat
);

  localparam int IW = DATA_WIDTH + ADDITIONAL_DELTA_WIDTH;
  localparam int SW = IW + 2;
  localparam logic signed [SW-1:0] C_MAX = SW'((2 ** (IW - 1)) - 1);
  localparam logic signed [SW-1:0] C_MIN = -SW'(2 ** (IW - 1));
  localparam logic signed [SW-1:0] C_FB  = SW'(FEEDBACK_MAG);

  logic signed [IW-1:0] int1_q, int1_d;
  logic signed [IW-1:0] int2_q, int2_d;
  logic                 bit_q, bit_d;
  logic                 valid_q, valid_d;
  logic                 sat_q, sat_d;

  logic signed [SW-1:0] x_ext, int1_ext, int2_ext, fb, sum1, sum2;
  logic                 q, clamp1, clamp2;

  function automatic logic signed [IW-1:0] f_sat(input logic signed [SW-1:0] v);
    logic signed [IW-1:0] r;
    if (v > C_MAX)      r = C_MAX[IW-1:0];
    else if (v < C_MIN) r = C_MIN[IW-1:0];
    else                r = v[IW-1:0];
    return r;
  endfunction

  always_comb begin
    x_ext    = {{(SW-DATA_WIDTH){i_data[DATA_WIDTH-1]}}, i_data};
    int1_ext = {{2{int1_q[IW-1]}}, int1_q};
    int2_ext = {{2{int2_q[IW-1]}}, int2_q};
    q        = (ORDER == 1) ? !int1_q[IW-1] : !int2_q[IW-1];
    fb       = q ? C_FB : -C_FB;
    sum1     = int1_ext + x_ext - fb;
    // Second stage integrates the pre-update int1 (delaying-integrator CIFB).
    sum2     = int2_ext + int1_ext - fb;
    clamp1   = (sum1 > C_MAX) || (sum1 < C_MIN);
    clamp2   = (ORDER != 1) && ((sum2 > C_MAX) || (sum2 < C_MIN));

    int1_d  = int1_q;
    int2_d  = int2_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    sat_d   = sat_q;
    if (i_clear) begin
      int1_d = '0;
      int2_d = '0;
      bit_d  = 1'b0;
      sat_d  = 1'b0;
    end else if (i_en) begin
      int1_d  = f_sat(sum1);
      int2_d  = (ORDER == 1) ? '0 : f_sat(sum2);
      bit_d   = q;
      valid_d = 1'b1;
      sat_d   = sat_q | clamp1 | clamp2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      int1_q  <= '0;
      int2_q  <= '0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      int1_q  <= int1_d;
      int2_q  <= int2_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign o_bit   = bit_q;
  assign o_valid = valid_q;
  assign o_sat   = sat_q;

endmodule
`default_nettype wire

// File: tb/tb_dsm_modulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dsm_modulator: directed checks on ORDER=1 and ORDER=2 instances.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_dsm_modulator;

  logic              clk;
  logic              rst_n;
  logic              en;
  logic              clr;
  logic signed [3:0] data;
  logic              bit1, valid1, sat1;
  logic              bit2, valid2, sat2;

  int n_checks = 0;
  int n_fail   = 0;

  dsm_modulator #(.DATA_WIDTH(4), .ADDITIONAL_DELTA_WIDTH(2), .FEEDBACK_MAG(8), .ORDER(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clear(clr), .i_data(data),
    .o_bit(bit1), .o_valid(valid1), .o_sat(sat1)
  );

  dsm_modulator #(.DATA_WIDTH(4), .ADDITIONAL_DELTA_WIDTH(2), .FEEDBACK_MAG(8), .ORDER(2)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clear(clr), .i_data(data),
    .o_bit(bit2), .o_valid(valid2), .o_sat(sat2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, return 1 time unit after the next rising edge.
  task automatic step(input logic e, input logic c, input logic signed [3:0] d);
    @(negedge clk);
    en   = e;
    clr  = c;
    data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    data  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_zero_input(input string tag);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 4'sd0);
      check({tag, "_bit"},   int'(bit1), (i % 2 == 0) ? 1 : 0);
      check({tag, "_int1"},  int'(u_dut1.int1_q), (i % 2 == 0) ? -8 : 0);
      check({tag, "_sat"},   int'(sat1), 0);
      check({tag, "_valid"}, int'(valid1), 1);
    end
  endtask

  initial begin
    int ones;
    int valids;
    int s2_bits[4];
    int s3_int2[6];
    int s3_bit[6];
    int s3_sat[6];
    s2_bits = '{1, 0, 1, 1};
    s3_int2 = '{-8, -16, -24, -32, -32, -32};
    s3_bit  = '{1, 0, 0, 0, 0, 0};
    s3_sat  = '{0, 0, 0, 0, 1, 1};

    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    data  = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("rst_bit",   int'(bit2), 0);
    check("rst_valid", int'(valid2), 0);
    check("rst_sat",   int'(sat2), 0);
    check("rst_int1",  int'(u_dut2.int1_q), 0);
    check("rst_int2",  int'(u_dut2.int2_q), 0);

    // Scenario 1: ORDER=1, x=0 gives alternating bits.
    run_zero_input("s1");

    // Scenario 2: ORDER=1, x=+4, 16 steps -> 12 ones.
    do_reset();
    ones   = 0;
    valids = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 4'sd4);
      check("s2_seq", int'(bit1), s2_bits[i % 4]);
      ones   += int'(bit1);
      valids += int'(valid1);
    end
    check("s2_ones",   ones, 12);
    check("s2_valids", valids, 16);
    step(1'b0, 1'b0, 4'sd4);
    check("s2_valid_off", int'(valid1), 0);

    // Scenario 3: ORDER=2, x=-8 drives int2 into the negative clamp.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, -4'sd8);
      check("s3_bit",  int'(bit2), s3_bit[i]);
      check("s3_int2", int'(u_dut2.int2_q), s3_int2[i]);
      check("s3_int1", int'(u_dut2.int1_q), -16);
      check("s3_sat",  int'(sat2), s3_sat[i]);
    end

    // Scenario 5: clear wins over enable while o_sat is high.
    step(1'b1, 1'b1, -4'sd8);
    check("s5_int1",  int'(u_dut2.int1_q), 0);
    check("s5_int2",  int'(u_dut2.int2_q), 0);
    check("s5_bit",   int'(bit2), 0);
    check("s5_valid", int'(valid2), 0);
    check("s5_sat",   int'(sat2), 0);
    step(1'b1, 1'b0, 4'sd0);
    check("s5_first_bit",   int'(bit2), 1);
    check("s5_first_valid", int'(valid2), 1);

    // Scenario 4: enable pattern 1,0,0,1 with x=+4.
    do_reset();
    step(1'b1, 1'b0, 4'sd4);
    check("s4_a_int1_o1", int'(u_dut1.int1_q), -4);
    check("s4_a_bit_o1",  int'(bit1), 1);
    check("s4_a_valid",   int'(valid1), 1);
    check("s4_a_int1_o2", int'(u_dut2.int1_q), -4);
    check("s4_a_int2_o2", int'(u_dut2.int2_q), -8);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 4'sd4);
      check("s4_h_valid",   int'(valid1), 0);
      check("s4_h_int1_o1", int'(u_dut1.int1_q), -4);
      check("s4_h_bit_o1",  int'(bit1), 1);
      check("s4_h_int1_o2", int'(u_dut2.int1_q), -4);
      check("s4_h_int2_o2", int'(u_dut2.int2_q), -8);
      check("s4_h_bit_o2",  int'(bit2), 1);
    end
    step(1'b1, 1'b0, 4'sd4);
    check("s4_b_int1_o1", int'(u_dut1.int1_q), 8);
    check("s4_b_bit_o1",  int'(bit1), 0);
    check("s4_b_valid",   int'(valid1), 1);
    check("s4_b_int1_o2", int'(u_dut2.int1_q), 8);
    check("s4_b_int2_o2", int'(u_dut2.int2_q), -4);
    check("s4_b_bit_o2",  int'(bit2), 0);

    // Scenario 6: asynchronous reset between clock edges.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, -4'sd8);
    check("s6_pre_sat",   int'(sat2), 1);
    check("s6_pre_valid", int'(valid2), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_async_sat",   int'(sat2), 0);
    check("s6_async_valid", int'(valid2), 0);
    check("s6_async_bit",   int'(bit2), 0);
    check("s6_async_int1",  int'(u_dut1.int1_q), 0);
    check("s6_async_int2",  int'(u_dut2.int2_q), 0);
    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    run_zero_input("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
